vga_timing_gen: RTL and testbench

Parametrised successor to the fixed 640x480 VGA controller.
- Generates horizontal/vertical counters, sync, blanking and frame/line markers for any VESA-style mode from one system clock.
- Replaces the toggled clk_25MHz with a parametrised pixel-enable strobe, so the whole design stays single-clock.
- Sits between clk_50MHz/clear and the pixel renderer / framebuffer reader.

---
 rtl/vga_pkg.sv | 59 +++++
 rtl/vga_timing_gen_if.sv | 30 +++
 rtl/pixel_strobe_gen.sv | 51 +++++
 rtl/vga_timing_gen.sv | 147 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Package  : vga_pkg
// Summary  : Shared VESA mode timing constants and elaboration-time helpers.
// Revision : 1.0 - initial release
// ============================================================================
package vga_pkg;

   typedef struct packed {
      int disp;
      int fp;
      int pw;
      int bp;
   } vga_axis_t;

   typedef struct packed {
      vga_axis_t h;
      vga_axis_t v;
      bit        h_pol;
      bit        v_pol;
   } vga_mode_t;

   localparam vga_mode_t VGA_640X480_60 = '{
      h     : '{640, 16,  96, 48},
      v     : '{480, 10,   2, 29},
      h_pol : 1'b0,
      v_pol : 1'b0
   };

   localparam vga_mode_t VGA_800X600_60 = '{
      h     : '{800, 40, 128, 88},
      v     : '{600,  1,   4, 23},
      h_pol : 1'b1,
      v_pol : 1'b1
   };

   function automatic int h_total(input int disp, input int fp, input int pw, input int bp);
      return disp + fp + pw + bp;
   endfunction

   function automatic int v_total(input int disp, input int fp, input int pw, input int bp);
      return disp + fp + pw + bp;
   endfunction

   // Bits needed to hold value distinct states (0 for value <= 1).
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Interface : vga_timing_gen_if
// Summary   : Timing bundle from the generator to the renderer / fb reader.
// Revision  : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if #(
   parameter int COUNTER_BITS = 10
);
   logic                    pix_en;
   logic [COUNTER_BITS-1:0] h_count;
   logic [COUNTER_BITS-1:0] v_count;
   logic                    h_sync;
   logic                    v_sync;
   logic                    bright;
   logic                    vblank;
   logic                    line_start;
   logic                    frame_start;

   modport master (
      output pix_en, h_count, v_count, h_sync, v_sync,
             bright, vblank, line_start, frame_start
   );

   modport slave (
      input  pix_en, h_count, v_count, h_sync, v_sync,
             bright, vblank, line_start, frame_start
   );
endinterface
`default_nettype wire

// File: rtl/pixel_strobe_gen.sv
`default_nettype none
// ============================================================================
// Module   : pixel_strobe_gen
// Summary  : Divides the system clock into a one-cycle pixel tick every CLK_DIV clocks.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_strobe_gen
   import vga_pkg::*;
#(
   parameter int CLK_DIV = 2
)(
   input  wire logic clk_50MHz,
   input  wire logic clear,
   input  wire logic enable,
   output logic      tick
);

   generate
      if (CLK_DIV < 1) begin : g_err_clk_div
         $error("pixel_strobe_gen: CLK_DIV must be at least 1");
      end

      if (CLK_DIV <= 1) begin : g_div_one
         // Every enabled clock is a pixel; the divider state collapses away.
         logic w_unused_div_one;
         assign w_unused_div_one = &{1'b0, clk_50MHz, clear};
         assign tick = enable;
      end else begin : g_div_n
         localparam int c_DIV_BITS = clog2(CLK_DIV);
         localparam logic [c_DIV_BITS-1:0] c_DIV_LAST = c_DIV_BITS'(CLK_DIV - 1);

         logic [c_DIV_BITS-1:0] r_div_cnt;

         always_ff @(posedge clk_50MHz) begin
            if (!clear) begin
               r_div_cnt <= '0;
            end else if (enable) begin
               if (r_div_cnt == c_DIV_LAST) begin
                  r_div_cnt <= '0;
               end else begin
                  r_div_cnt <= r_div_cnt + c_DIV_BITS'(1);
               end
            end
         end

         assign tick = enable && (r_div_cnt == c_DIV_LAST);
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Summary  : Parametrised VESA-style raster counters, sync, blanking and markers.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_DISP       = VGA_640X480_60.h.disp,
   parameter int H_FP         = VGA_640X480_60.h.fp,
   parameter int H_PW         = VGA_640X480_60.h.pw,
   parameter int H_BP         = VGA_640X480_60.h.bp,
   parameter int V_DISP       = VGA_640X480_60.v.disp,
   parameter int V_FP         = VGA_640X480_60.v.fp,
   parameter int V_PW         = VGA_640X480_60.v.pw,
   parameter int V_BP         = VGA_640X480_60.v.bp,
   parameter int CLK_DIV      = 2,
   parameter int H_SYNC_POL   = 0,
   parameter int V_SYNC_POL   = 0,
   parameter int COUNTER_BITS = 10
)(
   input  wire logic        clk_50MHz,
   input  wire logic        clear,
   input  wire logic        enable,
   vga_timing_gen_if.master vga
);

   localparam int c_H_TOTAL   = h_total(H_DISP, H_FP, H_PW, H_BP);
   localparam int c_V_TOTAL   = v_total(V_DISP, V_FP, V_PW, V_BP);
   localparam int c_MAX_TOTAL = (c_H_TOTAL > c_V_TOTAL) ? c_H_TOTAL : c_V_TOTAL;

   generate
      if (clog2(c_MAX_TOTAL) > COUNTER_BITS) begin : g_err_counter_bits
         $error("vga_timing_gen: COUNTER_BITS too small for H_TOTAL/V_TOTAL");
      end
      if (H_FP < 1 || H_PW < 1 || H_BP < 1 || V_FP < 1 || V_PW < 1 || V_BP < 1) begin : g_err_porch
         $error("vga_timing_gen: porch and sync widths must be non-zero");
      end
      if (CLK_DIV < 1) begin : g_err_clk_div
         $error("vga_timing_gen: CLK_DIV must be at least 1");
      end
   endgenerate

   localparam logic [COUNTER_BITS-1:0] c_H_LAST     = COUNTER_BITS'(c_H_TOTAL - 1);
   localparam logic [COUNTER_BITS-1:0] c_V_LAST     = COUNTER_BITS'(c_V_TOTAL - 1);
   localparam logic [COUNTER_BITS-1:0] c_H_DISP     = COUNTER_BITS'(H_DISP);
   localparam logic [COUNTER_BITS-1:0] c_V_DISP     = COUNTER_BITS'(V_DISP);
   localparam logic [COUNTER_BITS-1:0] c_HS_START   = COUNTER_BITS'(H_DISP + H_FP);
   localparam logic [COUNTER_BITS-1:0] c_HS_END     = COUNTER_BITS'(H_DISP + H_FP + H_PW);
   localparam logic [COUNTER_BITS-1:0] c_VS_START   = COUNTER_BITS'(V_DISP + V_FP);
   localparam logic [COUNTER_BITS-1:0] c_VS_END     = COUNTER_BITS'(V_DISP + V_FP + V_PW);
   localparam logic                    c_HS_ACTIVE  = (H_SYNC_POL != 0);
   localparam logic                    c_VS_ACTIVE  = (V_SYNC_POL != 0);

   logic                    w_tick;
   logic [COUNTER_BITS-1:0] w_h_next;
   logic [COUNTER_BITS-1:0] w_v_next;
   logic                    w_h_sync_next;
   logic                    w_v_sync_next;
   logic                    w_bright_next;
   logic                    w_vblank_next;
   logic                    w_line_start_next;
   logic                    w_frame_start_next;

   logic                    r_pix_en;
   logic [COUNTER_BITS-1:0] r_h_count;
   logic [COUNTER_BITS-1:0] r_v_count;
   logic                    r_h_sync;
   logic                    r_v_sync;
   logic                    r_bright;
   logic                    r_vblank;
   logic                    r_line_start;
   logic                    r_frame_start;

   pixel_strobe_gen #(
      .CLK_DIV   (CLK_DIV)
   ) u_pixel_strobe_gen (
      .clk_50MHz (clk_50MHz),
      .clear     (clear),
      .enable    (enable),
      .tick      (w_tick)
   );

   always_comb begin
      w_h_next = r_h_count;
      w_v_next = r_v_count;
      if (w_tick) begin
         if (r_h_count == c_H_LAST) begin
            w_h_next = '0;
            if (r_v_count == c_V_LAST) begin
               w_v_next = '0;
            end else begin
               w_v_next = r_v_count + COUNTER_BITS'(1);
            end
         end else begin
            w_h_next = r_h_count + COUNTER_BITS'(1);
         end
      end
   end

   // Decode from next-state counts so registered outputs line up with the counters.
   always_comb begin
      w_bright_next      = (w_h_next < c_H_DISP) && (w_v_next < c_V_DISP);
      w_vblank_next      = (w_v_next >= c_V_DISP);
      w_h_sync_next      = ((w_h_next >= c_HS_START) && (w_h_next < c_HS_END)) ? c_HS_ACTIVE : ~c_HS_ACTIVE;
      w_v_sync_next      = ((w_v_next >= c_VS_START) && (w_v_next < c_VS_END)) ? c_VS_ACTIVE : ~c_VS_ACTIVE;
      w_line_start_next  = w_tick && (w_h_next == '0);
      w_frame_start_next = w_line_start_next && (w_v_next == '0);
   end

   always_ff @(posedge clk_50MHz) begin
      if (!clear) begin
         r_pix_en      <= 1'b0;
         r_h_count     <= '0;
         r_v_count     <= '0;
         r_h_sync      <= ~c_HS_ACTIVE;
         r_v_sync      <= ~c_VS_ACTIVE;
         r_bright      <= 1'b1;
         r_vblank      <= 1'b0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_pix_en      <= w_tick;
         r_h_count     <= w_h_next;
         r_v_count     <= w_v_next;
         r_h_sync      <= w_h_sync_next;
         r_v_sync      <= w_v_sync_next;
         r_bright      <= w_bright_next;
         r_vblank      <= w_vblank_next;
         r_line_start  <= w_line_start_next;
         r_frame_start <= w_frame_start_next;
      end
   end

   assign vga.pix_en      = r_pix_en;
   assign vga.h_count     = r_h_count;
   assign vga.v_count     = r_v_count;
   assign vga.h_sync      = r_h_sync;
   assign vga.v_sync      = r_v_sync;
   assign vga.bright      = r_bright;
   assign vga.vblank      = r_vblank;
   assign vga.line_start  = r_line_start;
   assign vga.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Summary  : Self-checking bench: default mode plus two small modes vs a raster model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

   typedef struct {
      int hd, hfp, hpw, hbp;
      int vd, vfp, vpw, vbp;
      int div, hpol, vpol;
   } cfg_t;

   // Model state: divider phase, pixel index within the frame, last-edge pulses.
   typedef struct {
      int phase;
      int p;
      bit pix_en;
      bit ls;
      bit fs;
   } mdl_t;

   logic clk_50MHz = 1'b0;
   always #10 clk_50MHz = ~clk_50MHz;

   logic clear_a, enable_a, clear_b, enable_b, clear_c, enable_c;

   vga_timing_gen_if #(.COUNTER_BITS(10)) vga_a ();
   vga_timing_gen_if #(.COUNTER_BITS(5))  vga_b ();
   vga_timing_gen_if #(.COUNTER_BITS(4))  vga_c ();

   vga_timing_gen u_dut_a (
      .clk_50MHz (clk_50MHz),
      .clear     (clear_a),
      .enable    (enable_a),
      .vga       (vga_a)
   );

   vga_timing_gen #(
      .H_DISP(10), .H_FP(2), .H_PW(3), .H_BP(2),
      .V_DISP(6),  .V_FP(2), .V_PW(2), .V_BP(3),
      .CLK_DIV(1), .H_SYNC_POL(1), .V_SYNC_POL(1), .COUNTER_BITS(5)
   ) u_dut_b (
      .clk_50MHz (clk_50MHz),
      .clear     (clear_b),
      .enable    (enable_b),
      .vga       (vga_b)
   );

   vga_timing_gen #(
      .H_DISP(12), .H_FP(1), .H_PW(2), .H_BP(1),
      .V_DISP(5),  .V_FP(1), .V_PW(1), .V_BP(2),
      .CLK_DIV(3), .H_SYNC_POL(0), .V_SYNC_POL(0), .COUNTER_BITS(4)
   ) u_dut_c (
      .clk_50MHz (clk_50MHz),
      .clear     (clear_c),
      .enable    (enable_c),
      .vga       (vga_c)
   );

   int   total = 0;
   int   bad   = 0;
   cfg_t cfg_a, cfg_b, cfg_c;
   mdl_t m_a, m_b, m_c;
   int   n_bright, n_hsync;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic mdl_t mdl_step(input mdl_t s, input cfg_t c, input bit clr_n, input bit en);
      mdl_t n;
      int   ht;
      int   frame;
      n        = s;
      ht       = c.hd + c.hfp + c.hpw + c.hbp;
      frame    = ht * (c.vd + c.vfp + c.vpw + c.vbp);
      n.pix_en = 1'b0;
      n.ls     = 1'b0;
      n.fs     = 1'b0;
      if (!clr_n) begin
         n.phase = 0;
         n.p     = 0;
      end else if (en) begin
         n.phase = (s.phase + 1) % c.div;
         if (s.phase == c.div - 1) begin
            n.p      = (s.p + 1) % frame;
            n.pix_en = 1'b1;
            n.ls     = ((n.p % ht) == 0);
            n.fs     = (n.p == 0);
         end
      end
      return n;
   endfunction

   task automatic check_dut(input string name, input mdl_t s, input cfg_t c,
                            input logic pix_en, input logic [15:0] h, input logic [15:0] v,
                            input logic hs, input logic vs, input logic br, input logic vb,
                            input logic ls, input logic fs);
      int   ht, eh, ev;
      logic ehs, evs;
      ht  = c.hd + c.hfp + c.hpw + c.hbp;
      eh  = s.p % ht;
      ev  = s.p / ht;
      ehs = (eh >= c.hd + c.hfp && eh < c.hd + c.hfp + c.hpw) ? c.hpol[0] : !c.hpol[0];
      evs = (ev >= c.vd + c.vfp && ev < c.vd + c.vfp + c.vpw) ? c.vpol[0] : !c.vpol[0];
      check_val({name, ".pix_en"},      pix_en, s.pix_en);
      check_val({name, ".h_count"},     h,      eh);
      check_val({name, ".v_count"},     v,      ev);
      check_val({name, ".h_sync"},      hs,     ehs);
      check_val({name, ".v_sync"},      vs,     evs);
      check_val({name, ".bright"},      br,     (eh < c.hd) && (ev < c.vd));
      check_val({name, ".vblank"},      vb,     ev >= c.vd);
      check_val({name, ".line_start"},  ls,     s.ls);
      check_val({name, ".frame_start"}, fs,     s.fs);
   endtask

   // Predict the coming edge from the inputs now applied, pass it, then compare.
   task automatic tick_cycle();
      m_a = mdl_step(m_a, cfg_a, clear_a, enable_a);
      m_b = mdl_step(m_b, cfg_b, clear_b, enable_b);
      m_c = mdl_step(m_c, cfg_c, clear_c, enable_c);
      @(negedge clk_50MHz);
      check_dut("A", m_a, cfg_a, vga_a.pix_en, 16'(vga_a.h_count), 16'(vga_a.v_count),
                vga_a.h_sync, vga_a.v_sync, vga_a.bright, vga_a.vblank,
                vga_a.line_start, vga_a.frame_start);
      check_dut("B", m_b, cfg_b, vga_b.pix_en, 16'(vga_b.h_count), 16'(vga_b.v_count),
                vga_b.h_sync, vga_b.v_sync, vga_b.bright, vga_b.vblank,
                vga_b.line_start, vga_b.frame_start);
      check_dut("C", m_c, cfg_c, vga_c.pix_en, 16'(vga_c.h_count), 16'(vga_c.v_count),
                vga_c.h_sync, vga_c.v_sync, vga_c.bright, vga_c.vblank,
                vga_c.line_start, vga_c.frame_start);
   endtask

   task automatic set_all(input logic clr_n, input logic en);
      clear_a = clr_n; enable_a = en;
      clear_b = clr_n; enable_b = en;
      clear_c = clr_n; enable_c = en;
   endtask

   initial begin
      cfg_a = '{640, 16, 96, 48, 480, 10, 2, 29, 2, 0, 0};
      cfg_b = '{10, 2, 3, 2, 6, 2, 2, 3, 1, 1, 1};
      cfg_c = '{12, 1, 2, 1, 5, 1, 1, 2, 3, 0, 0};
      m_a   = '{0, 0, 1'b0, 1'b0, 1'b0};
      m_b   = m_a;
      m_c   = m_a;

      set_all(1'b0, 1'b0);
      repeat (3) tick_cycle();
      check_val("A.reset_h_count", 32'(vga_a.h_count), 0);
      check_val("A.reset_bright",  vga_a.bright, 1);
      check_val("A.reset_h_sync",  vga_a.h_sync, 1);
      check_val("A.reset_pix_en",  vga_a.pix_en, 0);
      check_val("B.reset_h_sync",  vga_b.h_sync, 0);
      check_val("B.reset_v_sync",  vga_b.v_sync, 0);

      // First line of the default mode: 1600 clocks at two clocks per pixel.
      set_all(1'b1, 1'b1);
      n_bright = 0;
      n_hsync  = 0;
      for (int n = 1; n <= 1600; n++) begin
         tick_cycle();
         if (vga_a.bright === 1'b1) n_bright++;
         if (vga_a.h_sync === 1'b0) n_hsync++;
         if (n == 1599) check_val("A.line_start_pre_wrap", vga_a.line_start, 0);
      end
      check_val("A.wrap_h_count",    32'(vga_a.h_count), 0);
      check_val("A.wrap_v_count",    32'(vga_a.v_count), 1);
      check_val("A.wrap_line_start", vga_a.line_start, 1);
      check_val("A.bright_clocks",   n_bright, 1280);
      check_val("A.h_sync_clocks",   n_hsync, 192);

      // Freeze at h=300 on the first clock that position appears.
      for (int k = 0; k < 4000 && !(vga_a.h_count == 10'd300 && vga_a.pix_en === 1'b1); k++)
         tick_cycle();
      check_val("A.reach_h300", 32'(vga_a.h_count), 300);
      enable_a = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick_cycle();
         check_val("A.freeze_h_count", 32'(vga_a.h_count), 300);
         check_val("A.freeze_pix_en",  vga_a.pix_en, 0);
      end
      enable_a = 1'b1;
      tick_cycle();
      check_val("A.resume_hold_h", 32'(vga_a.h_count), 300);
      tick_cycle();
      check_val("A.resume_h",      32'(vga_a.h_count), 301);
      check_val("A.resume_pix_en", vga_a.pix_en, 1);

      // Clear in the middle of the line.
      for (int k = 0; k < 2000 && vga_a.h_count != 10'd700; k++)
         tick_cycle();
      check_val("A.reach_h700", 32'(vga_a.h_count), 700);
      clear_a = 1'b0;
      tick_cycle();
      check_val("A.clear_h_count",     32'(vga_a.h_count), 0);
      check_val("A.clear_v_count",     32'(vga_a.v_count), 0);
      check_val("A.clear_frame_start", vga_a.frame_start, 0);
      check_val("A.clear_pix_en",      vga_a.pix_en, 0);
      clear_a = 1'b1;
      tick_cycle();
      check_val("A.release_pix_en", vga_a.pix_en, 0);
      tick_cycle();
      check_val("A.release_tick_h", 32'(vga_a.h_count), 1);

      // Randomized enable/clear traffic on all three instances.
      for (int n = 0; n < 30000; n++) begin
         clear_a  = ($urandom_range(3999, 0) != 0);
         enable_a = ($urandom_range(7, 0) != 0);
         clear_b  = ($urandom_range(1499, 0) != 0);
         enable_b = ($urandom_range(3, 0) != 0);
         clear_c  = ($urandom_range(2999, 0) != 0);
         enable_c = ($urandom_range(7, 0) != 0);
         tick_cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
